aes_round_sched: RTL
====================

Name: aes_round_sched

Overview:
Iterative AES-128 round scheduler. It accepts one plaintext block per handshake and sequences the shared round datapath through the initial AddRoundKey, rounds 1..NR-1 and the final round. It requests each round key from the key-expansion unit and stalls when that key is not yet available. It sits between the top-level I/O wrapper and the round/key datapath, in the same clock domain as the trigger/state-monitor logic that observes `state` and the round keys.

Parameters:
NR, 10, number of AES rounds (10 for AES-128); legal range 2..14.
RND_W, 4, width of round index; must satisfy 2^RND_W > NR.
TIMEOUT, 16, consecutive key-wait cycles before abort with error; legal range 1..255.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  plaintext block and key present on datapath inputs
in_ready  out  1  scheduler can accept a block
abort  in  1  synchronous cancel of the current block
rk_valid  in  1  key expansion presents round key for current round_idx
rk_req  out  1  request round key for round_idx
ld_state  out  1  load state register with plaintext XOR rk0
rnd_en  out  1  datapath executes one round this cycle
final_round  out  1  current round skips MixColumns
round_idx  out  RND_W  round number being processed / key index requested
busy  out  1  block in flight
out_valid  out  1  ciphertext valid on datapath state output
out_ready  in  1  consumer takes ciphertext
err  out  1  one-cycle pulse: key-wait timeout

Behaviour:
- Clocking and reset: one clock `clk`, synchronous active-high reset `rst`. `rst` has priority over every input.
- Reset values: state=IDLE, round_idx=0, wait counter=0, err=0. Consequently in_ready=1 in the first cycle after reset, and ld_state, rnd_en, rk_req, final_round, busy and out_valid are all 0.
- States: IDLE, INIT, RUN, LAST, DONE. All registers update on the rising edge.
- IDLE:
  - in_ready=1, round_idx=0.
  - in_valid=1 → INIT.
  - abort is ignored in IDLE.
- INIT (exactly one cycle):
  - ld_state=1, round_idx=0, busy=1.
  - Next state is RUN with round_idx=1. If NR=1 were allowed the next state would be LAST; NR=1 is excluded by the parameter range.
- RUN:
  - rk_req=1, busy=1.
  - rnd_en = rk_valid (combinational); final_round=0.
  - On rnd_en: round_idx increments. When round_idx==NR-1, the next state is LAST with round_idx=NR.
- LAST:
  - rk_req=1, final_round=1, rnd_en = rk_valid.
  - On rnd_en → DONE; round_idx holds at NR.
- DONE:
  - out_valid=1, busy=1, rk_req=0.
  - Held until out_ready=1, then → IDLE with round_idx=0.
  - out_valid is never dropped without out_ready.
- Outputs:
  - in_ready is high only in IDLE, so no new block is accepted in the same cycle as DONE→IDLE. Back-to-back blocks are spaced by at least one IDLE cycle.
  - busy = state != IDLE.
- Key wait / timeout:
  - The 8-bit wait counter increments on each RUN/LAST cycle with rk_valid=0.
  - It clears on rnd_en and on any state change.
  - If the counter reaches TIMEOUT-1 and rk_valid=0 in that cycle: err=1 for that cycle, next state=IDLE, round_idx=0, no out_valid.
- Abort:
  - abort=1 in INIT/RUN/LAST/DONE → next state IDLE, round_idx=0, counter=0, no err.
  - abort has priority over rnd_en and over out_ready in the same cycle; that round's rnd_en is still asserted combinationally but its result is discarded.
- Simultaneous events, priority order: rst > abort > timeout > normal transition.
- Latency: with rk_valid held 1, out_valid first rises NR+2 cycles after the accepting edge (12 for NR=10).

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 → in_ready=1, busy=0, round_idx=0, all strobes 0.
- Nominal block, NR=10, rk_valid=1, out_ready=1: accept at edge 0 → ld_state in cycle 1; rnd_en cycles 2..11 with round_idx 1..10; final_round only in cycle 11; out_valid cycle 12; in_ready back in cycle 13.
- Key stall: rk_valid=0 during round 4 for 3 cycles → round_idx stays 4, rnd_en=0 and rk_req=1 for those cycles; out_valid delayed to cycle 15; err=0.
- Timeout, TIMEOUT=16: rk_valid=0 from round 2 onward → err pulses in the 16th wait cycle; next cycle state=IDLE, in_ready=1; out_valid never asserted.
- Output backpressure: out_ready=0 for 5 cycles in DONE → out_valid held 5 cycles, in_ready=0; out_ready=1 → IDLE next edge.
- Abort/reset mid-operation: abort=1 at round_idx=6 together with rk_valid=1 → next cycle IDLE, round_idx=0, err=0. Repeat using rst=1 instead of abort → same result, and in_valid asserted in the reset cycle is ignored.

Source files
------------

// File: rtl/aes_round_sched_if.sv
// Control bus between the AES round scheduler and the I/O wrapper / round-key datapath.
// "slave" is the scheduler side; "master" is the wrapper/datapath side.
interface aes_round_sched_if #(
    parameter int RND_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic             rk_valid;
    logic             rk_req;
    logic             ld_state;
    logic             rnd_en;
    logic             final_round;
    logic [RND_W-1:0] round_idx;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic             err;

    modport master (
        output in_valid, abort, rk_valid, out_ready,
        input  in_ready, rk_req, ld_state, rnd_en, final_round,
               round_idx, busy, out_valid, err
    );

    modport slave (
        input  in_valid, abort, rk_valid, out_ready,
        output in_ready, rk_req, ld_state, rnd_en, final_round,
               round_idx, busy, out_valid, err
    );
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: initial AddRoundKey, rounds 1..NR-1, final round,
// with key-availability stalls, key-wait timeout and synchronous abort.
module aes_round_sched #(
    parameter int NR      = 10,
    parameter int RND_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, LAST, DONE} state_e;

    localparam logic [RND_W-1:0] IDX_ONE = RND_W'(1);
    localparam logic [RND_W-1:0] IDX_PEN = RND_W'(NR - 1);
    localparam logic [RND_W-1:0] IDX_NR  = RND_W'(NR);
    localparam logic [7:0]       WT_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [RND_W-1:0] idx_q, idx_d;
    logic [7:0]       wcnt_q, wcnt_d;

    logic in_ready_q, busy_q, ld_q, rk_req_q, final_q, out_valid_q;
    logic rnd_en, timeout;

    // rk_req_q is high exactly in RUN/LAST, the only states that consume keys.
    assign rnd_en  = rk_req_q & bus.rk_valid;
    assign timeout = rk_req_q & ~bus.rk_valid & (wcnt_q == WT_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                idx_d  = '0;
                wcnt_d = '0;
                if (bus.in_valid) state_d = INIT;
            end
            INIT: begin
                state_d = RUN;
                idx_d   = IDX_ONE;
            end
            RUN: begin
                if (rnd_en) begin
                    wcnt_d = '0;
                    if (idx_q == IDX_PEN) begin
                        state_d = LAST;
                        idx_d   = IDX_NR;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            LAST: begin
                if (rnd_en) begin
                    state_d = DONE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                wcnt_d  = '0;
            end
        endcase

        // abort outranks timeout, which outranks the normal transition
        if ((state_q != IDLE && bus.abort) || timeout) begin
            state_d = IDLE;
            idx_d   = '0;
            wcnt_d  = '0;
        end

        if (state_d != state_q) wcnt_d = '0;
    end

    // Strobes are decoded from the next state so they come straight out of flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            ld_q        <= 1'b0;
            rk_req_q    <= 1'b0;
            final_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            ld_q        <= (state_d == INIT);
            rk_req_q    <= (state_d == RUN) || (state_d == LAST);
            final_q     <= (state_d == LAST);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.ld_state    = ld_q;
    assign bus.rk_req      = rk_req_q;
    assign bus.rnd_en      = rnd_en;
    assign bus.final_round = final_q;
    assign bus.round_idx   = idx_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.err         = timeout & ~bus.abort;
endmodule
